// File: rtl/vehicle_sensor_conditioner_pkg.sv
// Shared definitions for the loop-detector conditioner: channel state encoding,
// default timing constants and the demand decode used by both channels.
package vehicle_sensor_conditioner_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_QUAL    = 3'd1,
    ST_PRESENT = 3'd2,
    ST_EXTEND  = 3'd3,
    ST_FAULT   = 3'd4
  } chan_state_e;

  localparam int DEF_DEB_CYCLES   = 4;
  localparam int DEF_EXT_CYCLES   = 8;
  localparam int DEF_STUCK_CYCLES = 1024;
  localparam int DEF_CNT_W        = 11;

  // FAULT keeps demand asserted so a stuck approach is still served.
  function automatic logic state_demands(input chan_state_e st);
    return (st == ST_PRESENT) || (st == ST_EXTEND) || (st == ST_FAULT);
  endfunction

endpackage

// File: rtl/vehicle_sensor_conditioner_if.sv
// One conditioning channel: raw detector and clear in, demand/fault/debug state out.
interface vehicle_sensor_conditioner_if;
  import vehicle_sensor_conditioner_pkg::*;

  logic        det_raw;
  logic        fault_clr;
  logic        demand;
  logic        fault;
  chan_state_e state;

  modport master (output det_raw, fault_clr, input demand, fault, state);
  modport slave  (input det_raw, fault_clr, output demand, fault, state);

endinterface

// File: rtl/vehicle_sensor_conditioner_channel.sv
// Single approach: 2-FF synchronizer, debounce / gap-extension / stuck-on FSM and
// sticky fault flag. Outputs decode registered state only.
module vehicle_sensor_conditioner_channel
  import vehicle_sensor_conditioner_pkg::*;
#(
  parameter int DEB_CYCLES   = DEF_DEB_CYCLES,
  parameter int EXT_CYCLES   = DEF_EXT_CYCLES,
  parameter int STUCK_CYCLES = DEF_STUCK_CYCLES,
  parameter int CNT_W        = DEF_CNT_W
) (
  input logic                         clk,
  input logic                         reset_n,
  vehicle_sensor_conditioner_if.slave ch
);

  localparam logic [CNT_W-1:0] L_ZERO       = '0;
  localparam logic [CNT_W-1:0] L_ONE        = CNT_W'(1);
  localparam logic [CNT_W-1:0] L_DEB_LAST   = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] L_EXT_LAST   = CNT_W'(EXT_CYCLES);
  localparam logic [CNT_W-1:0] L_STUCK_LAST = CNT_W'(STUCK_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  chan_state_e      r_state;
  chan_state_e      w_state_nx;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nx;
  logic [CNT_W-1:0] r_stuck_cnt;
  logic [CNT_W-1:0] w_stuck_nx;
  logic             r_fault;
  logic             w_fault_nx;
  logic             w_s;

  assign w_s = r_sync2;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1     <= 1'b0;
      r_sync2     <= 1'b0;
      r_state     <= ST_IDLE;
      r_cnt       <= L_ZERO;
      r_stuck_cnt <= L_ZERO;
      r_fault     <= 1'b0;
    end else begin
      r_sync1     <= ch.det_raw;
      r_sync2     <= r_sync1;
      r_state     <= w_state_nx;
      r_cnt       <= w_cnt_nx;
      r_stuck_cnt <= w_stuck_nx;
      r_fault     <= w_fault_nx;
    end
  end

  // Every limit compare forces a transition, so neither counter can wrap.
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_stuck_nx = r_stuck_cnt;
    w_fault_nx = ch.fault_clr ? 1'b0 : r_fault;
    case (r_state)
      ST_IDLE: begin
        if (w_s) begin
          w_state_nx = ST_QUAL;
          w_cnt_nx   = L_ONE;
        end
      end
      ST_QUAL: begin
        if (!w_s) begin
          w_state_nx = ST_IDLE;
          w_cnt_nx   = L_ZERO;
        end else if (r_cnt == L_DEB_LAST) begin
          w_state_nx = ST_PRESENT;
          w_stuck_nx = L_ZERO;
        end else begin
          w_cnt_nx = r_cnt + L_ONE;
        end
      end
      ST_PRESENT: begin
        if (!w_s) begin
          w_state_nx = ST_EXTEND;
          w_cnt_nx   = L_ONE;
        end else if (r_stuck_cnt == L_STUCK_LAST) begin
          // Fault entry overrides a simultaneous clear.
          w_state_nx = ST_FAULT;
          w_fault_nx = 1'b1;
          w_cnt_nx   = L_ZERO;
        end else begin
          w_stuck_nx = r_stuck_cnt + L_ONE;
        end
      end
      ST_EXTEND: begin
        if (w_s) begin
          w_state_nx = ST_PRESENT;
          w_stuck_nx = L_ZERO;
        end else if (r_cnt == L_EXT_LAST) begin
          w_state_nx = ST_IDLE;
        end else begin
          w_cnt_nx = r_cnt + L_ONE;
        end
      end
      ST_FAULT: begin
        if (ch.fault_clr) begin
          w_state_nx = ST_IDLE;
          w_cnt_nx   = L_ZERO;
        end else if (w_s) begin
          w_cnt_nx = L_ZERO;
        end else if (r_cnt == L_DEB_LAST) begin
          w_state_nx = ST_IDLE;
        end else begin
          w_cnt_nx = r_cnt + L_ONE;
        end
      end
      default: begin
        w_state_nx = ST_IDLE;
        w_cnt_nx   = L_ZERO;
      end
    endcase
  end

  assign ch.demand = state_demands(r_state);
  assign ch.fault  = r_fault;
  assign ch.state  = r_state;

endmodule

// File: rtl/vehicle_sensor_conditioner.sv
// Conditions both approach loop detectors into demand levels Sa/Sb with stuck-on
// fault flags. Wiring only; each approach is an independent channel instance.
module vehicle_sensor_conditioner
  import vehicle_sensor_conditioner_pkg::*;
#(
  parameter int DEB_CYCLES   = DEF_DEB_CYCLES,
  parameter int EXT_CYCLES   = DEF_EXT_CYCLES,
  parameter int STUCK_CYCLES = DEF_STUCK_CYCLES,
  parameter int CNT_W        = DEF_CNT_W
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        det_a_raw,
  input  logic        det_b_raw,
  input  logic        fault_clr,
  output logic        Sa,
  output logic        Sb,
  output logic        fault_a,
  output logic        fault_b,
  output chan_state_e o_dbg_state_a,
  output chan_state_e o_dbg_state_b
);

  vehicle_sensor_conditioner_if w_chan_a ();
  vehicle_sensor_conditioner_if w_chan_b ();

  assign w_chan_a.det_raw   = det_a_raw;
  assign w_chan_a.fault_clr = fault_clr;
  assign w_chan_b.det_raw   = det_b_raw;
  assign w_chan_b.fault_clr = fault_clr;

  vehicle_sensor_conditioner_channel #(
    .DEB_CYCLES(DEB_CYCLES), .EXT_CYCLES(EXT_CYCLES),
    .STUCK_CYCLES(STUCK_CYCLES), .CNT_W(CNT_W)
  ) u_chan_a (
    .clk(clk), .reset_n(reset_n), .ch(w_chan_a.slave)
  );

  vehicle_sensor_conditioner_channel #(
    .DEB_CYCLES(DEB_CYCLES), .EXT_CYCLES(EXT_CYCLES),
    .STUCK_CYCLES(STUCK_CYCLES), .CNT_W(CNT_W)
  ) u_chan_b (
    .clk(clk), .reset_n(reset_n), .ch(w_chan_b.slave)
  );

  assign Sa            = w_chan_a.demand;
  assign Sb            = w_chan_b.demand;
  assign fault_a       = w_chan_a.fault;
  assign fault_b       = w_chan_b.fault;
  assign o_dbg_state_a = w_chan_a.state;
  assign o_dbg_state_b = w_chan_b.state;

endmodule

// File: tb/tb_vehicle_sensor_conditioner.sv
// Bench for vehicle_sensor_conditioner: per-cycle scoreboard against a channel
// reference model plus directed latency, glitch, stuck-on and clear scenarios.
`timescale 1ns/1ps
module tb_vehicle_sensor_conditioner;
  import vehicle_sensor_conditioner_pkg::*;

  localparam int DEB   = 4;
  localparam int EXT   = 8;
  localparam int STUCK = 32;
  localparam int CNT_W = 6;

  logic clk     = 1'b0;
  logic reset_n = 1'b1;

  vehicle_sensor_conditioner_if a_if ();
  vehicle_sensor_conditioner_if b_if ();

  int n_tests = 0;
  int n_fail  = 0;

  logic [9:0] exp_q[$];
  logic [9:0] sb_exp;
  logic [9:0] sb_got;

  // Reference model state, index 0 = approach A, 1 = approach B.
  logic m_s1[2];
  logic m_s2[2];
  int   m_st[2];
  int   m_cnt[2];
  int   m_stk[2];
  logic m_f[2];

  vehicle_sensor_conditioner #(
    .DEB_CYCLES(DEB), .EXT_CYCLES(EXT), .STUCK_CYCLES(STUCK), .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .det_a_raw(a_if.det_raw),
    .det_b_raw(b_if.det_raw),
    .fault_clr(a_if.fault_clr),
    .Sa(a_if.demand),
    .Sb(b_if.demand),
    .fault_a(a_if.fault),
    .fault_b(b_if.fault),
    .o_dbg_state_a(a_if.state),
    .o_dbg_state_b(b_if.state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      m_s1[c] = 1'b0; m_s2[c] = 1'b0; m_st[c] = 0;
      m_cnt[c] = 0; m_stk[c] = 0; m_f[c] = 1'b0;
    end
  endtask

  task automatic model_chan(input int c, input logic raw, input logic clr);
    logic s;
    int   nst, ncnt, nstk;
    logic nf;
    s = m_s2[c]; nst = m_st[c]; ncnt = m_cnt[c]; nstk = m_stk[c]; nf = m_f[c];
    case (m_st[c])
      0: if (s) begin nst = 1; ncnt = 1; end
      1: if (!s) begin nst = 0; ncnt = 0; end
         else if (m_cnt[c] == DEB - 1) begin nst = 2; nstk = 0; end
         else ncnt = m_cnt[c] + 1;
      2: if (!s) begin nst = 3; ncnt = 1; end
         else if (m_stk[c] == STUCK - 1) begin nst = 4; ncnt = 0; end
         else nstk = m_stk[c] + 1;
      3: if (s) begin nst = 2; nstk = 0; end
         else if (m_cnt[c] == EXT) nst = 0;
         else ncnt = m_cnt[c] + 1;
      default: if (clr) begin nst = 0; ncnt = 0; end
         else if (s) ncnt = 0;
         else if (m_cnt[c] == DEB - 1) nst = 0;
         else ncnt = m_cnt[c] + 1;
    endcase
    if (m_st[c] == 2 && nst == 4) nf = 1'b1;
    else if (clr) nf = 1'b0;
    m_st[c] = nst; m_cnt[c] = ncnt; m_stk[c] = nstk; m_f[c] = nf;
    m_s2[c] = m_s1[c]; m_s1[c] = raw;
  endtask

  function automatic logic [9:0] model_vec();
    logic [2:0] sa, sb;
    sa = 3'(m_st[0]);
    sb = 3'(m_st[1]);
    return {(m_st[0] >= 2), (m_st[1] >= 2), m_f[0], m_f[1], sa, sb};
  endfunction

  // ---------------- driver ----------------
  task automatic step(input logic a, input logic b, input logic clr);
    a_if.det_raw   = a;
    b_if.det_raw   = b;
    a_if.fault_clr = clr;
    model_chan(0, a, clr);
    model_chan(1, b, clr);
    exp_q.push_back(model_vec());
    @(posedge clk);
    @(negedge clk);
  endtask

  // ---------------- scoreboard ----------------
  always @(posedge clk) begin
    #2;
    if (exp_q.size() > 0) begin
      sb_exp = exp_q.pop_front();
      sb_got = {a_if.demand, b_if.demand, a_if.fault, b_if.fault, a_if.state, b_if.state};
      n_tests++;
      if (sb_got !== sb_exp) begin
        n_fail++;
        $display("FAIL scoreboard t=%0t {Sa,Sb,fa,fb,stA,stB} got=%b exp=%b", $time, sb_got, sb_exp);
      end
    end
  end

  // ---------------- tests ----------------
  task automatic test_reset();
    reset_n = 1'b0;
    a_if.det_raw = 1'b0; b_if.det_raw = 1'b0; a_if.fault_clr = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    n_tests++;
    if ({a_if.demand, b_if.demand, a_if.fault, b_if.fault} !== 4'b0000 ||
        a_if.state !== ST_IDLE || b_if.state !== ST_IDLE) begin
      n_fail++;
      $display("FAIL reset_initial outputs=%b stA=%0d stB=%0d expected 0000/0/0",
               {a_if.demand, b_if.demand, a_if.fault, b_if.fault}, a_if.state, b_if.state);
    end
    reset_n = 1'b1;
    repeat (8) step(1'b1, 1'b1, 1'b0);
    n_tests++;
    if (a_if.demand !== 1'b1 || b_if.demand !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_pre_present Sa=%b Sb=%b expected 1 1", a_if.demand, b_if.demand);
    end
    #2 reset_n = 1'b0;
    #1;
    n_tests++;
    if ({a_if.demand, b_if.demand, a_if.fault, b_if.fault} !== 4'b0000 ||
        a_if.state !== ST_IDLE || b_if.state !== ST_IDLE) begin
      n_fail++;
      $display("FAIL reset_async outputs=%b stA=%0d stB=%0d expected 0000/0/0",
               {a_if.demand, b_if.demand, a_if.fault, b_if.fault}, a_if.state, b_if.state);
    end
    exp_q.delete();
    model_reset();
    a_if.det_raw = 1'b0; b_if.det_raw = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      step(1'b0, 1'b0, 1'b0);
      n_tests++;
      if (a_if.demand !== 1'b0 || b_if.demand !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_release step %0d Sa=%b Sb=%b expected 0 0", i, a_if.demand, b_if.demand);
      end
    end
  endtask

  task automatic test_debounce();
    for (int i = 1; i <= 8; i++) begin
      step(i <= 3, 1'b0, 1'b0);
      n_tests++;
      if (a_if.demand !== 1'b0) begin
        n_fail++;
        $display("FAIL debounce_glitch step %0d Sa=%b expected 0", i, a_if.demand);
      end
    end
    for (int i = 1; i <= 6; i++) begin
      step(1'b1, 1'b0, 1'b0);
      n_tests++;
      if (a_if.demand !== (i == 6) || b_if.demand !== 1'b0) begin
        n_fail++;
        $display("FAIL debounce_rise step %0d Sa=%b Sb=%b expected %b 0",
                 i, a_if.demand, b_if.demand, (i == 6));
      end
    end
  endtask

  task automatic test_extension();
    for (int i = 1; i <= 11; i++) begin
      step(i > 5, 1'b0, 1'b0);
      n_tests++;
      if (a_if.demand !== 1'b1) begin
        n_fail++;
        $display("FAIL extension_dropout step %0d Sa=%b expected 1", i, a_if.demand);
      end
    end
    for (int i = 1; i <= 12; i++) begin
      step(1'b0, 1'b0, 1'b0);
      n_tests++;
      if (a_if.demand !== (i < 11)) begin
        n_fail++;
        $display("FAIL extension_fall step %0d Sa=%b expected %b", i, a_if.demand, (i < 11));
      end
    end
  endtask

  task automatic test_stuck();
    for (int i = 1; i <= 45; i++) begin
      step(1'b0, 1'b1, 1'b0);
      n_tests++;
      if (b_if.demand !== (i >= 6) || b_if.fault !== (i >= 38) || a_if.demand !== 1'b0) begin
        n_fail++;
        $display("FAIL stuck_hold step %0d Sb=%b fault_b=%b Sa=%b expected %b %b 0",
                 i, b_if.demand, b_if.fault, a_if.demand, (i >= 6), (i >= 38));
      end
    end
    for (int i = 1; i <= 8; i++) begin
      step(1'b0, 1'b0, 1'b0);
      n_tests++;
      if (b_if.demand !== (i < 6) || b_if.fault !== 1'b1) begin
        n_fail++;
        $display("FAIL stuck_release step %0d Sb=%b fault_b=%b expected %b 1",
                 i, b_if.demand, b_if.fault, (i < 6));
      end
    end
    step(1'b0, 1'b0, 1'b1);
    n_tests++;
    if (b_if.fault !== 1'b0 || b_if.state !== ST_IDLE) begin
      n_fail++;
      $display("FAIL stuck_clear fault_b=%b stB=%0d expected 0 0", b_if.fault, b_if.state);
    end
  endtask

  task automatic test_clear_collision();
    for (int i = 1; i <= 38; i++) step(1'b0, 1'b1, i == 38);
    n_tests++;
    if (b_if.fault !== 1'b1 || b_if.state !== ST_FAULT || b_if.demand !== 1'b1) begin
      n_fail++;
      $display("FAIL collision_entry fault_b=%b stB=%0d Sb=%b expected 1 4 1",
               b_if.fault, b_if.state, b_if.demand);
    end
    repeat (2) step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    n_tests++;
    if (b_if.demand !== 1'b0 || b_if.fault !== 1'b0 || b_if.state !== ST_IDLE) begin
      n_fail++;
      $display("FAIL collision_clear Sb=%b fault_b=%b stB=%0d expected 0 0 0",
               b_if.demand, b_if.fault, b_if.state);
    end
    repeat (8) step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_independence();
    int   run_a = 0;
    int   run_b = 0;
    logic a = 1'b0;
    logic b = 1'b0;
    logic clr;
    for (int i = 0; i < 800; i++) begin
      if (run_a <= 0) begin
        a = ~a;
        run_a = ($urandom_range(0, 4) == 0) ? int'($urandom_range(25, 45)) : int'($urandom_range(1, 10));
      end
      if (run_b <= 0) begin
        b = ~b;
        run_b = ($urandom_range(0, 4) == 0) ? int'($urandom_range(25, 45)) : int'($urandom_range(1, 10));
      end
      clr = ($urandom_range(0, 39) == 0);
      step(a, b, clr);
      run_a--;
      run_b--;
    end
    repeat (15) step(1'b0, 1'b0, 1'b0);
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    model_reset();
    #1;
    test_reset();
    test_debounce();
    test_extension();
    test_stuck();
    test_clear_collision();
    test_independence();
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
